// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin write arbiter feeding a FIFO, with a mirrored occupancy count.
// Optional macro FIFO_ARB_HWM_EN adds the occ_hwm high-water-mark output. Rev 1.0
`default_nettype none

`ifndef WIDTH
`define WIDTH 8
`endif

module fifo_write_arbiter #(
   parameter int WIDTH = `WIDTH,
   parameter int N_REQ = 4,
   parameter int DEPTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ*WIDTH-1:0]       req_data,
   output logic [N_REQ-1:0]             req_ready,
   input  logic                         cons_read,
   output logic                         fifo_write,
   output logic [WIDTH-1:0]             fifo_data,
   output logic [$clog2(N_REQ)-1:0]     grant_id,
   output logic                         fifo_read,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         cons_valid
`ifdef FIFO_ARB_HWM_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0]   occ_hwm
`endif
);

   localparam int PW = $clog2(N_REQ);
   localparam int OW = $clog2(DEPTH+1);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic [PW-1:0] cand;
   logic          found;
   logic          space;
   logic          transfer;
   logic [OW-1:0] occ_next;

   // A write still in the output register already claims a FIFO slot.
   assign space = ({1'b0, occ} + {{OW{1'b0}}, fifo_write}) < (OW+1)'(DEPTH);

   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = PW'((int'(rr_ptr) + k) % N_REQ);
         if (!found && req_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
      req_ready = '0;
      if (found && space && !reset)
         req_ready[grant_idx] = 1'b1;
   end

   assign transfer   = |(req_valid & req_ready);
   assign fifo_read  = cons_read & (occ != '0);
   assign cons_valid = (occ != '0);
   assign occ_next   = occ + OW'(fifo_write) - OW'(fifo_read);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         occ        <= '0;
         fifo_write <= 1'b0;
         fifo_data  <= '0;
         grant_id   <= '0;
      end else begin
         fifo_write <= transfer;
         occ        <= occ_next;
         if (transfer) begin
            fifo_data <= req_data[grant_idx*WIDTH +: WIDTH];
            grant_id  <= grant_idx;
            rr_ptr    <= (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_HWM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         occ_hwm <= '0;
      else if (occ_next > occ_hwm)
         occ_hwm <= occ_next;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for fifo_write_arbiter (WIDTH=8, N_REQ=4, DEPTH=32).
`default_nettype none

module tb_fifo_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        cons_read;
   logic        fifo_write;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic        fifo_read;
   logic [5:0]  occ;
   logic        cons_valid;
`ifdef FIFO_ARB_HWM_EN
   logic [5:0]  occ_hwm;
`endif

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   fifo_write_arbiter #(.WIDTH(8), .N_REQ(4), .DEPTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .cons_read  (cons_read),
      .fifo_write (fifo_write),
      .fifo_data  (fifo_data),
      .grant_id   (grant_id),
      .fifo_read  (fifo_read),
      .occ        (occ),
      .cons_valid (cons_valid)
`ifdef FIFO_ARB_HWM_EN
      ,
      .occ_hwm    (occ_hwm)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_occ"}, occ, 0);
      check({tag, "_wr"}, fifo_write, 0);
      check({tag, "_data"}, fifo_data, 0);
      check({tag, "_gid"}, grant_id, 0);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_rd"}, fifo_read, 0);
      check({tag, "_cvalid"}, cons_valid, 0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'hF;
      cons_read = 1'b1;
      req_data  = '0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
`ifdef FIFO_ARB_HWM_EN
      check("reset_hwm", occ_hwm, 0);
`endif

      // Fill: all four valid, no reads
      @(negedge clk);
      reset     = 1'b0;
      cons_read = 1'b0;
      req_valid = 4'hF;
      req_data  = 32'h13121110;
      for (int c = 0; c < 36; c++) begin
         #1;
         check("fill_ready", req_ready, (c < 32) ? (4'b0001 << (c % 4)) : 4'b0000);
         check("fill_wr", fifo_write, (c >= 1 && c <= 32) ? 1 : 0);
         if (c >= 1 && c <= 32) begin
            check("fill_gid", grant_id, (c - 1) % 4);
            check("fill_data", fifo_data, 8'h10 + 8'((c - 1) % 4));
         end
         check("fill_occ", occ, (c <= 1) ? 0 : ((c - 1 > 32) ? 32 : c - 1));
         if (fifo_write) pulses++;
         @(negedge clk);
      end
      #1;
      check("fill_pulses", pulses, 32);
      check("fill_occ_final", occ, 32);
`ifdef FIFO_ARB_HWM_EN
      check("fill_hwm", occ_hwm, 32);
`endif

      // Pop one, then requester 2 takes the last slot
      req_valid = 4'b0000;
      cons_read = 1'b1;
      #1 check("full_rd", fifo_read, 1);
      @(negedge clk);
      cons_read = 1'b0;
      req_valid = 4'b0100;
      req_data[23:16] = 8'hA5;
      #1;
      check("last_occ", occ, 31);
      check("last_ready", req_ready, 4'b0100);
      @(negedge clk);
      #1;
      check("last_wr", fifo_write, 1);
      check("last_data", fifo_data, 8'hA5);
      check("last_gid", grant_id, 2);
      check("last_ready_off", req_ready, 0);
      @(negedge clk);
      #1;
      check("last_occ_full", occ, 32);
      check("last_wr_off", fifo_write, 0);
      check("last_ready_full", req_ready, 0);

      // Drain to empty, then write with reads pending
      req_valid = 4'b0000;
      cons_read = 1'b1;
      repeat (32) @(negedge clk);
      #1;
      check("drain_occ", occ, 0);
      check("drain_rd", fifo_read, 0);
      check("drain_cvalid", cons_valid, 0);
`ifdef FIFO_ARB_HWM_EN
      check("drain_hwm", occ_hwm, 32);
`endif
      req_valid = 4'b0010;
      req_data[15:8] = 8'h3C;
      #1;
      check("empty_ready", req_ready, 4'b0010);
      check("empty_rd", fifo_read, 0);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check("empty_wr", fifo_write, 1);
      check("empty_gid", grant_id, 1);
      check("empty_data", fifo_data, 8'h3C);
      check("empty_rd_blk", fifo_read, 0);
      check("empty_occ0", occ, 0);
      @(negedge clk);
      #1;
      check("empty_occ1", occ, 1);
      check("empty_rd_on", fifo_read, 1);
      check("empty_cvalid", cons_valid, 1);
      check("empty_wr_off", fifo_write, 0);
      @(negedge clk);
      #1;
      check("empty_occ_back", occ, 0);
      check("empty_rd_off", fifo_read, 0);

      // Fill to 10, then simultaneous write+read keeps occ steady
      cons_read = 1'b0;
      req_valid = 4'hF;
      repeat (10) @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      #1 check("ten_occ", occ, 10);
      req_valid = 4'hF;
      @(negedge clk);
      cons_read = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         check("steady_occ", occ, 10);
         check("steady_wr", fifo_write, 1);
         check("steady_rd", fifo_read, 1);
         @(negedge clk);
      end
      req_valid = 4'b0000;
      @(negedge clk);
      repeat (5) @(negedge clk);
      #1;
      check("five_occ", occ, 5);
      check("five_wr", fifo_write, 0);
      cons_read = 1'b0;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check("pre_rst_wr", fifo_write, 1);
      check("pre_rst_occ", occ, 5);

      // Mid-stream asynchronous reset
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
`ifdef FIFO_ARB_HWM_EN
      check("async_rst_hwm", occ_hwm, 0);
`endif
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 4'b0011;
      #1;
      check("post_rst_ready", req_ready, 4'b0001);
      check("post_rst_occ", occ, 0);
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      check("post_rst_wr", fifo_write, 1);
      check("post_rst_gid", grant_id, 0);
      check("post_rst_data", fifo_data, 8'h10);
      check("post_rst_occ0", occ, 0);
      check("post_rst_ready1", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check("post_rst_gid1", grant_id, 1);
      check("post_rst_occ1", occ, 1);
      @(negedge clk);
      #1;
      check("post_rst_occ2", occ, 2);
`ifdef FIFO_ARB_HWM_EN
      check("post_rst_hwm", occ_hwm, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter WIDTH, default `WIDTH, data word width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; the legal range is 2..8.
REQ-003 Parameter DEPTH, default 32, depth of the downstream FIFO; it SHALL equal that FIFO's DEPTH.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester write request.
REQ-007 req_data  input  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  N_REQ  one-hot-or-zero grant; a transfer occurs on req_valid[i] & req_ready[i].
REQ-009 cons_read  input  1  consumer pop request.
REQ-010 fifo_write  output  1  registered write strobe to the FIFO.
REQ-011 fifo_data  output  WIDTH  registered write data to the FIFO.
REQ-012 grant_id  output  $clog2(N_REQ)  registered index of the requester whose word is on fifo_data.
REQ-013 fifo_read  output  1  gated pop strobe to the FIFO (combinational).
REQ-014 occ  output  $clog2(DEPTH+1)  mirrored FIFO occupancy (register).
REQ-015 cons_valid  output  1  asserted when occ != 0.

Function
REQ-016 The block SHALL grant at most one requester per cycle, using round-robin order starting from rr_ptr and searching upward modulo N_REQ.
REQ-017 The block SHALL grant only when (occ + fifo_write) < DEPTH; otherwise req_ready SHALL be all zero.
REQ-018 req_ready[i] SHALL be 1 only if req_valid[i] = 1, i is the first valid requester at or after rr_ptr, and REQ-017 holds.
REQ-019 On a transfer by requester i, rr_ptr SHALL become (i+1) mod N_REQ on the next edge; otherwise rr_ptr SHALL hold.
REQ-020 On the edge after a transfer, the block SHALL drive fifo_write=1, fifo_data=req_data[i] and grant_id=i for exactly one cycle per transfer; the latency is 1 cycle.
REQ-021 Back-to-back transfers on consecutive cycles SHALL produce fifo_write held high on consecutive cycles with no bubble.
REQ-022 fifo_read SHALL equal cons_read & (occ != 0), which blocks any pop of an empty FIFO and any simultaneous write+read at count 0.
REQ-023 fifo_write SHALL never be 1 while occ = DEPTH; this follows from REQ-017.
REQ-024 The occ update on each edge SHALL be occ + fifo_write - fifo_read.
  - Both strobes high: occ holds.
  - occ SHALL never exceed DEPTH or underflow.
REQ-025 A requester that deasserts req_valid before being granted SHALL lose nothing; the arbiter SHALL hold no state per requester.
REQ-026 With N_REQ requesters continuously valid and space available, each requester SHALL be granted exactly once in every N_REQ consecutive grants.

Reset
REQ-027 While reset=1, the following SHALL be zero: rr_ptr, occ, fifo_write, fifo_data, grant_id and (if compiled in) occ_hwm.
  - req_ready, fifo_read and cons_valid SHALL then evaluate to 0.
REQ-028 A reset asserted mid-stream SHALL abort any registered write, which SHALL not be counted.
  - The FIFO SHALL share the same reset so that occupancy stays consistent.
REQ-029 After reset deassertion, the first grant SHALL go to the lowest-index valid requester.

Configuration
REQ-030 With macro FIFO_ARB_HWM_EN defined, the block SHALL add output occ_hwm, width $clog2(DEPTH+1), holding the maximum occ value since reset.
  - It SHALL be updated on the same edge that occ updates.
REQ-031 Without FIFO_ARB_HWM_EN, the port occ_hwm and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then req_valid=4'b1111 held with cons_read=0 and DEPTH=32 -> grant order 0,1,2,3,0,...; exactly 32 fifo_write pulses; req_ready=0 once occ+fifo_write=32; occ settles at 32.
REQ-033 occ=0, cons_read=1 held -> fifo_read stays 0 until fifo_write lands; occ goes 0->1->0; no lost word; grant_id matches the source.
REQ-034 occ=31, fifo_write=0, requester 2 valid with data 0xA5 -> one grant; next cycle fifo_data=0xA5 and grant_id=2; occ becomes 32 and req_ready returns to 0.
REQ-035 occ=10, one transfer and cons_read=1 every cycle for 20 cycles -> occ stays 10 once the first write lands; fifo_write and fifo_read are both high each cycle.
REQ-036 Assert reset for 1 cycle while fifo_write=1 and occ=5 -> all outputs 0 immediately; after release, requester 1 alone valid is granted first.
REQ-037 With FIFO_ARB_HWM_EN: fill to 20, then drain to 0 -> occ_hwm=20 and holds until reset.
